// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX write-port arbiter.
//   state_e : arbiter FSM encodings (IDLE / ECHO / MSG)
//   grant_e : which requester received the most recent grant
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ECHO = 2'd1,
    MSG  = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_ECHO = 1'b0,
    GRANT_MSG  = 1'b1
  } grant_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_echo_queue.sv
// Small synchronous FIFO that buffers echo bytes, which arrive as
// one-cycle strobes and cannot be back-pressured.
//   clk, rst : clock, asynchronous active-high reset (pointers only)
//   push/din : write request and data
//   pop      : read request; dout always shows the head entry
//   full     : all 2**ECHO_AW entries occupied
//   empty    : no entries
module uart_tx_arbiter_echo_queue #(
  parameter int ECHO_AW = 2,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ECHO_AW;
  localparam logic [ECHO_AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ECHO_AW:0]  wr_ptr_q, wr_ptr_d;
  logic [ECHO_AW:0]  rd_ptr_q, rd_ptr_d;
  logic              wr_en;
  logic              rd_en;

  // The extra pointer MSB distinguishes full from empty when the
  // address bits coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ECHO_AW] != rd_ptr_q[ECHO_AW]) &&
                 (wr_ptr_q[ECHO_AW-1:0] == rd_ptr_q[ECHO_AW-1:0]);

  assign rd_en = pop & ~empty;
  // A simultaneous pop frees a slot, so a full queue can still accept.
  assign wr_en = push & (~full | rd_en);

  assign dout = mem_q[rd_ptr_q[ECHO_AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ECHO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the single UART TX FIFO write port between the command-decoder
// echo path (strobed bytes, queued internally) and the message/status
// reporter (valid/ready/last packets written atomically). Round-robin
// arbitration happens only at packet boundaries.
//   clk, rst            : clock, asynchronous active-high reset
//   echo_stb, echo_data : one-cycle echo byte strobe
//   msg_valid, msg_data, msg_last, msg_ready : message byte handshake
//   fifo_full           : TX FIFO full
//   fifo_push, fifo_wdata : TX FIFO write port
//   busy                : arbiter is serving a grant
//   echo_ovf            : sticky, an echo byte was dropped
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int ECHO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo_stb,
  input  logic [7:0]  echo_data,
  input  logic        msg_valid,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  input  logic        fifo_full,
  output logic        fifo_push,
  output logic [7:0]  fifo_wdata,
  output logic        busy,
  output logic        echo_ovf
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              echo_ovf_q, echo_ovf_d;

  logic              q_pop;
  logic [BYTE_W-1:0] q_head;
  logic              q_full;
  logic              q_empty;

  uart_tx_arbiter_echo_queue #(
    .ECHO_AW (ECHO_AW),
    .DATA_W  (BYTE_W)
  ) u_echo_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (echo_stb),
    .pop   (q_pop),
    .din   (echo_data),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // State register and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_MSG;
      echo_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      echo_ovf_q   <= echo_ovf_d;
    end
  end

  // A strobe is lost only when the queue is full and not draining now.
  always_comb begin
    echo_ovf_d = echo_ovf_q | (echo_stb & q_full & ~q_pop);
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (msg_valid && !q_empty) begin
          // Tie: the side that did not win last time gets the port.
          if (last_grant_q == GRANT_MSG) begin
            state_d      = ECHO;
            last_grant_d = GRANT_ECHO;
          end else begin
            state_d      = MSG;
            last_grant_d = GRANT_MSG;
          end
        end else if (!q_empty) begin
          state_d      = ECHO;
          last_grant_d = GRANT_ECHO;
        end else if (msg_valid) begin
          state_d      = MSG;
          last_grant_d = GRANT_MSG;
        end
      end
      ECHO: begin
        // One echo byte per grant keeps message latency bounded.
        if (!fifo_full) state_d = IDLE;
      end
      MSG: begin
        // Stay through valid gaps so the packet is never split.
        if (msg_valid && !fifo_full && msg_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_push  = 1'b0;
    fifo_wdata = 8'h00;
    msg_ready  = 1'b0;
    q_pop      = 1'b0;
    unique case (state_q)
      ECHO: begin
        fifo_push  = ~fifo_full;
        fifo_wdata = q_head;
        q_pop      = ~fifo_full;
      end
      MSG: begin
        msg_ready  = ~fifo_full;
        fifo_push  = msg_valid & ~fifo_full;
        fifo_wdata = msg_data;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign echo_ovf = echo_ovf_q;

endmodule
